// File: rtl/alu_exec_stage.sv
// alu_exec_stage
//   Registered execute stage. Computes add/sub/and/or/slt on two's-complement
//   operands selected by a 3-bit ALU control code, flags zero / signed
//   overflow / illegal code, and hands the result to write-back through a
//   valid/ready handshake. A main output register plus a skid register keep
//   one op per cycle while in_ready comes straight from a flop.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   flush                  drop every buffered and incoming operation
//   in_valid / in_ready    upstream handshake (in_ready = !skid full)
//   alu_ctrl, op_a, op_b   operation code and operands
//   in_tag                 destination tag, carried with its result
//   out_valid / out_ready  downstream handshake
//   out_result, out_zero, out_ovf, out_err, out_tag  held operation
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PW = WIDTH + TAG_W + 3;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // Packet layout: {err, ovf, zero, tag, result}; reset image has zero=1.
  localparam logic [PW-1:0] RST_PKT = {3'b001, {TAG_W{1'b0}}, {WIDTH{1'b0}}};

  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  // ---- stage p0: combinational compute on the incoming operation ----
  logic signed [WIDTH-1:0] a_p0, b_p0, sum_p0, diff_p0, res_p0;
  logic                    aovf_p0, sovf_p0, ovf_p0, err_p0, zero_p0;
  logic [PW-1:0]           pkt_p0;

  assign a_p0    = op_a;
  assign b_p0    = op_b;
  assign sum_p0  = a_p0 + b_p0;
  assign diff_p0 = a_p0 - b_p0;
  assign aovf_p0 = add_ovf(a_p0[WIDTH-1], b_p0[WIDTH-1], sum_p0[WIDTH-1]);
  assign sovf_p0 = sub_ovf(a_p0[WIDTH-1], b_p0[WIDTH-1], diff_p0[WIDTH-1]);

  always_comb begin
    res_p0 = '0;
    ovf_p0 = 1'b0;
    err_p0 = 1'b0;
    case (alu_ctrl)
      OP_ADD: begin res_p0 = sum_p0;  ovf_p0 = aovf_p0; end
      OP_SUB: begin res_p0 = diff_p0; ovf_p0 = sovf_p0; end
      OP_AND: res_p0 = a_p0 & b_p0;
      OP_OR:  res_p0 = a_p0 | b_p0;
      // Sign of the difference corrected by overflow stays right at the extremes.
      OP_SLT: res_p0 = {{(WIDTH-1){1'b0}}, diff_p0[WIDTH-1] ^ sovf_p0};
      default: err_p0 = 1'b1;
    endcase
  end

  assign zero_p0 = (res_p0 == '0);
  assign pkt_p0  = {err_p0, ovf_p0, zero_p0, in_tag, res_p0};

  // ---- stage p1: output register + skid register ----
  logic          vld_p1, skid_vld_p1;
  logic [PW-1:0] out_pkt_p1, skid_pkt_p1;
  logic          accept, load_out;

  assign accept   = in_valid & ~skid_vld_p1;
  assign load_out = ~vld_p1 | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      out_pkt_p1  <= RST_PKT;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (load_out) begin
      if (skid_vld_p1) begin
        out_pkt_p1  <= skid_pkt_p1;
        vld_p1      <= 1'b1;
        skid_vld_p1 <= 1'b0;
      end else if (accept) begin
        out_pkt_p1 <= pkt_p0;
        vld_p1     <= 1'b1;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (accept) begin
      skid_vld_p1 <= 1'b1;
    end
  end

  // Skid data is only meaningful while skid_vld_p1 is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept && !load_out) begin
      skid_pkt_p1 <= pkt_p0;
    end
  end

  assign in_ready   = ~skid_vld_p1;
  assign out_valid  = vld_p1;
  assign out_err    = out_pkt_p1[PW-1];
  assign out_ovf    = out_pkt_p1[PW-2];
  assign out_zero   = out_pkt_p1[PW-3];
  assign out_tag    = out_pkt_p1[WIDTH +: TAG_W];
  assign out_result = out_pkt_p1[WIDTH-1:0];

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;

  localparam int WIDTH = 32;
  localparam int TAG_W = 5;
  localparam int PW    = WIDTH + TAG_W + 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       alu_ctrl = 3'b000;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_result;
  logic             out_zero, out_ovf, out_err;
  logic [TAG_W-1:0] out_tag;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [PW-1:0] sb[$];

  alu_exec_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_ovf(out_ovf),
    .out_err(out_err), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] mk(input logic [WIDTH-1:0] r, input logic z,
                                       input logic o, input logic e,
                                       input logic [TAG_W-1:0] t);
    return {e, o, z, t, r};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops on every drain; while stalled the held output must equal the head.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        if (out_ready) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_output: got tag %0d result 0x%0h, expected nothing",
                   out_tag, out_result);
        end
      end else begin
        check(out_ready ? "drain" : "stall_hold",
              {24'd0, out_err, out_ovf, out_zero, out_tag, out_result}, {24'd0, sb[0]});
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // Drive one op; entered at posedge+1, returns at posedge+1 after its accept edge.
  task automatic send(input logic [2:0] c, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] t,
                      input logic [WIDTH-1:0] r, input logic z, input logic o,
                      input logic e);
    bit done = 0;
    in_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b; in_tag = t;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(mk(r, z, o, e, t));
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: tag %0d never accepted, in_ready=%0b expected 1", t, in_ready);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_result",    64'(out_result), 64'd0);
    check("rst_flags",     64'({out_zero, out_ovf, out_err}), 64'b100);
    check("rst_tag",       64'(out_tag), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Arithmetic and compare corner cases
    send(3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd3, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    check("latency_out_valid", 64'(out_valid), 64'd1);
    send(3'b110, 32'd5, 32'd5, 5'd4, 32'd0, 1'b1, 1'b0, 1'b0);
    send(3'b111, 32'h8000_0000, 32'h0000_0001, 5'd5, 32'd1, 1'b0, 1'b0, 1'b0);
    send(3'b111, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'd0, 1'b1, 1'b0, 1'b0);

    // Back-to-back logic ops, output never stalled
    send(3'b000, 32'h0000_F0F0, 32'h0000_FF00, 5'd7, 32'h0000_F000, 1'b0, 1'b0, 1'b0);
    check("b2b_in_ready_0", 64'(in_ready), 64'd1);
    send(3'b001, 32'h0000_F0F0, 32'h0000_0F0F, 5'd8, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
    check("b2b_in_ready_1", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk); #1;

    // Downstream stall: tag 1 to output, tag 2 to skid, tag 3 waits
    out_ready = 1'b0;
    send(3'b010, 32'd1, 32'd2, 5'd1, 32'd3, 1'b0, 1'b0, 1'b0);
    check("stall_in_ready_1", 64'(in_ready), 64'd1);
    send(3'b010, 32'd3, 32'd4, 5'd2, 32'd7, 1'b0, 1'b0, 1'b0);
    check("stall_in_ready_2", 64'(in_ready), 64'd0);
    fork
      send(3'b001, 32'd0, 32'd0, 5'd3, 32'd0, 1'b1, 1'b0, 1'b0);
      begin
        repeat (3) @(posedge clk); #1;
        check("stall_held_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk); #1;

    // Illegal codes are delivered with err set
    send(3'b100, 32'h1234_5678, 32'h9ABC_DEF0, 5'd9,  32'd0, 1'b1, 1'b0, 1'b1);
    send(3'b011, 32'hFFFF_FFFF, 32'h0000_0001, 5'd10, 32'd0, 1'b1, 1'b0, 1'b1);
    repeat (2) @(posedge clk); #1;

    // Flush with both entries full and an incoming op
    out_ready = 1'b0;
    send(3'b000, 32'hFFFF_FFFF, 32'h0000_00AA, 5'd11, 32'h0000_00AA, 1'b0, 1'b0, 1'b0);
    send(3'b000, 32'hFFFF_FFFF, 32'h0000_00BB, 5'd12, 32'h0000_00BB, 1'b0, 1'b0, 1'b0);
    check("full_in_ready", 64'(in_ready), 64'd0);
    flush = 1'b1; in_valid = 1'b1; alu_ctrl = 3'b010;
    op_a = 32'd100; op_b = 32'd1; in_tag = 5'd13;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk); #1;

    // Stage still works after the flush
    send(3'b110, 32'h8000_0000, 32'h0000_0001, 5'd14, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered execute stage that consumes the 3-bit ALU control code produced by the ALU control decoder together with two operands and a destination tag. It computes add/sub/and/or/slt, produces zero, overflow and error flags, and presents the result to the write-back side through a valid/ready handshake. A two-entry output buffer (main register plus skid register) sustains one operation per cycle while keeping `in_ready` driven from a flop.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width in bits (≥ 2).
- `TAG_W`, 5: destination-register tag width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous drop of all buffered and incoming operations.
- `in_valid`  in  1  upstream has an operation.
- `in_ready`  out  1  stage can accept; equals NOT `skid_valid` (flop-driven).
- `alu_ctrl`  in  3  operation code: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `op_a`, `op_b`  in  WIDTH  operands, two's complement.
- `in_tag`  in  TAG_W  destination tag, passed through unchanged.
- `out_valid`  out  1  result register holds a valid operation.
- `out_ready`  in  1  downstream accepts.
- `out_result`  out  WIDTH  computed result.
- `out_zero`  out  1  `out_result` == 0.
- `out_ovf`  out  1  signed overflow (add/sub only).
- `out_err`  out  1  `alu_ctrl` was not one of the five legal codes.
- `out_tag`  out  TAG_W  tag of the held operation.

## Operation
- Accept = `in_valid` & `in_ready`. Drain = `out_valid` & `out_ready`.
- Arithmetic is computed combinationally on input and captured into the buffer. The computed value, not the operands, is stored.
- add: `op_a + op_b` mod 2^WIDTH. sub: `op_a - op_b` mod 2^WIDTH.
- ovf for add = operands have the same sign and the result sign differs. ovf for sub = operand signs differ and the result sign differs from `op_a`. ovf = 0 for and/or/slt.
- and/or: bitwise. slt: result = 1 if signed `op_a` < `op_b`, else 0. Computed as the sign of (a−b) XOR sub-overflow, so it stays correct at the extremes.
- Illegal code (011, 100, 101): result 0, zero 1, ovf 0, err 1. The operation is still accepted and delivered; it is not dropped.
- Buffer update, with `flush` taking priority over all of the following:
  - `flush`=1: `out_valid` and `skid_valid` cleared, any same-cycle accept is discarded. Data registers are don't-care.
  - Output register empty, or drained this cycle: load from skid if `skid_valid` (and clear skid), else load from input if accept, else clear `out_valid`.
  - Output register full and not drained, with an accept: the input goes to the skid register and `skid_valid` is set.
  - Skid full implies `in_ready`=0, so an accept and a skid→out move never coincide.
- Ordering is strictly FIFO; `out_tag` follows its own result.

## Timing
- Reset (asynchronous, while `rst_n`=0): `out_valid`=0, `skid_valid`=0, so `in_ready`=1. `out_result`=0, `out_zero`=1, `out_ovf`=0, `out_err`=0, `out_tag`=0. No accept takes effect while reset is asserted.
- Latency: an operation accepted at edge N is visible with `out_valid`=1 immediately after edge N.
- Throughput: 1 op/cycle with `out_ready` held high; the skid register stays empty.
- Downstream stall: one further op is absorbed into skid, and `in_ready` falls after that edge. When `out_ready` returns, skid moves to output on that edge and `in_ready` rises the same edge.
- Outputs stay stable while `out_valid`=1 and `out_ready`=0.
- Reset mid-operation: buffered ops are lost and no partial result is emitted.

## Test plan
- Reset, then add 0x7FFFFFFF + 0x00000001, tag 3 → after 1 edge: result 0x80000000, ovf 1, zero 0, err 0, tag 3.
- sub 5 − 5 → result 0, zero 1, ovf 0. Then slt 0x80000000 vs 0x00000001 → result 1. Then slt 0x7FFFFFFF vs 0xFFFFFFFF → result 0.
- Back-to-back and(0xF0F0,0xFF00)=0xF000 and or(0xF0F0,0x0F0F)=0xFFFF with `out_ready`=1 → one result per cycle, `in_ready` stays 1.
- Hold `out_ready`=0 and stream tags 1,2,3 → tags 1 and 2 are buffered, `in_ready`=0 after the second accept, tag 3 waits. Release `out_ready` → tags delivered in order 1,2,3 with no loss or duplication.
- `alu_ctrl`=100 with any operands → result 0, zero 1, err 1, op delivered with its tag.
- With both entries full, assert `flush` together with `in_valid` → next cycle `out_valid`=0, `in_ready`=1, and nothing from the flushed or incoming ops ever appears.
